// File: rtl/ebi_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ebi_pkg : shared EBI channel IDs, message lengths, flit and credit constants
// Rev 1.1
// ----------------------------------------------------------------------------
package ebi_pkg;

  localparam int M2_M1_CHANNEL_NUM = 3;
  localparam int ID_B  = 0;
  localparam int ID_AC = 1;
  localparam int ID_R  = 2;

  localparam int B_MSG_LEN  = 40;
  localparam int AC_MSG_LEN = 100;
  localparam int R_MSG_LEN  = 230;

  localparam int MAX_M2_M1_MESSAGE_LENGTH =
    (R_MSG_LEN > AC_MSG_LEN) ? ((R_MSG_LEN > B_MSG_LEN) ? R_MSG_LEN : B_MSG_LEN)
                             : ((AC_MSG_LEN > B_MSG_LEN) ? AC_MSG_LEN : B_MSG_LEN);

  localparam int EBI_FLIT_WIDTH    = 64;
  localparam int EBI_VC_CREDIT_NUM = 2;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  // Positional order follows ID_B, ID_AC, ID_R (0, 1, 2).
  localparam int M2_M1_FLIT_NUM [M2_M1_CHANNEL_NUM] = '{
    ceil_div(B_MSG_LEN,  EBI_FLIT_WIDTH),
    ceil_div(AC_MSG_LEN, EBI_FLIT_WIDTH),
    ceil_div(R_MSG_LEN,  EBI_FLIT_WIDTH)
  };

endpackage
`default_nettype wire

// File: rtl/ebi_rr_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ebi_rr_arbiter : round-robin arbiter, search starts at ptr and wraps at N
// Rev 1.0
// ----------------------------------------------------------------------------
module ebi_rr_arbiter
  import ebi_pkg::*;
#(
  parameter int N      = 3,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  always_comb begin : p_search
    logic [IDX_W:0] w_sum;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    w_sum     = '0;
    for (int i = 0; i < N; i++) begin
      w_sum = {1'b0, ptr} + (IDX_W+1)'(i);
      if (w_sum >= (IDX_W+1)'(N)) begin
        w_sum = w_sum - (IDX_W+1)'(N);
      end
      if (!any && req[w_sum[IDX_W-1:0]]) begin
        any       = 1'b1;
        grant_idx = w_sum[IDX_W-1:0];
      end
    end
    if (any) begin
      grant[grant_idx] = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/m2_ebi_tx_packer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// m2_ebi_tx_packer : credit-gated round-robin packer of M2->M1 messages into link flits
// Rev 1.0
// ----------------------------------------------------------------------------
module m2_ebi_tx_packer
  import ebi_pkg::*;
#(
  parameter int CH_NUM     = M2_M1_CHANNEL_NUM,
  parameter int MSG_LEN    = MAX_M2_M1_MESSAGE_LENGTH,
  parameter int FLIT_W     = EBI_FLIT_WIDTH,
  parameter int CREDIT_NUM = EBI_VC_CREDIT_NUM,
  localparam int VC_W      = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic                      m2_clk_i,
  input  logic                      rst_i,
  input  logic [CH_NUM-1:0]         m2_m1_channel_entry_valid_i,
  output logic [CH_NUM-1:0]         m2_m1_channel_push_ready_o,
  input  logic [CH_NUM*MSG_LEN-1:0] m2_m1_channel_hs_entry_i,
  output logic                      tx_flit_valid_o,
  input  logic                      tx_flit_ready_i,
  output logic [FLIT_W-1:0]         tx_flit_o,
  output logic [VC_W-1:0]           tx_flit_vc_o,
  output logic                      tx_flit_head_o,
  output logic                      tx_flit_tail_o,
  input  logic [CH_NUM-1:0]         credit_return_i,
  output logic                      credit_overflow_o
);

  localparam int c_BEAT_NUM = (MSG_LEN + FLIT_W - 1) / FLIT_W;
  localparam int c_SHADOW_W = c_BEAT_NUM * FLIT_W;
  localparam int c_BEAT_W   = (c_BEAT_NUM > 1) ? $clog2(c_BEAT_NUM) : 1;
  localparam int c_CRED_W   = $clog2(CREDIT_NUM + 1);

  localparam logic [0:0] c_IDLE = 1'b0;
  localparam logic [0:0] c_SEND = 1'b1;

  logic [0:0]            r_state;
  logic [c_SHADOW_W-1:0] r_shadow;
  logic [VC_W-1:0]       r_vc;
  logic [c_BEAT_W-1:0]   r_beat;
  logic [VC_W-1:0]       r_rr_ptr;
  logic [c_CRED_W-1:0]   r_credit [CH_NUM];
  logic                  r_overflow;

  logic [CH_NUM-1:0]     w_eligible;
  logic [CH_NUM-1:0]     w_grant;
  logic [VC_W-1:0]       w_grant_idx;
  logic                  w_any;
  logic [MSG_LEN-1:0]    w_entry;
  logic [FLIT_W-1:0]     w_flit;
  logic [c_BEAT_W-1:0]   w_last_beat;
  logic                  w_send;
  logic                  w_tail;
  logic [CH_NUM-1:0]     w_push;

  always_comb begin
    w_eligible = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      w_eligible[i] = m2_m1_channel_entry_valid_i[i] && (r_credit[i] != '0);
    end
  end

  ebi_rr_arbiter #(
    .N (CH_NUM)
  ) u_arb (
    .req       (w_eligible),
    .ptr       (r_rr_ptr),
    .grant     (w_grant),
    .grant_idx (w_grant_idx),
    .any       (w_any)
  );

  assign w_send = (r_state == c_SEND);
  assign w_push = (r_state == c_IDLE) ? w_grant : '0;

  always_comb begin
    w_entry = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (w_grant[i]) begin
        w_entry = m2_m1_channel_hs_entry_i[i*MSG_LEN +: MSG_LEN];
      end
    end
  end

  // Shadow is zero-padded to whole flits, so the last flit reads 0 above MSG_LEN.
  always_comb begin
    w_flit = '0;
    for (int b = 0; b < c_BEAT_NUM; b++) begin
      if (r_beat == c_BEAT_W'(b)) begin
        w_flit = r_shadow[b*FLIT_W +: FLIT_W];
      end
    end
  end

  always_comb begin
    w_last_beat = '0;
    for (int v = 0; v < CH_NUM; v++) begin
      if (r_vc == VC_W'(v)) begin
        w_last_beat = c_BEAT_W'(M2_M1_FLIT_NUM[v] - 1);
      end
    end
  end

  assign w_tail = (r_beat == w_last_beat);

  always_ff @(posedge m2_clk_i) begin
    if (rst_i) begin
      r_state  <= c_IDLE;
      r_shadow <= '0;
      r_vc     <= '0;
      r_beat   <= '0;
      r_rr_ptr <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_any) begin
            r_shadow <= c_SHADOW_W'(w_entry);
            r_vc     <= w_grant_idx;
            r_beat   <= '0;
            r_state  <= c_SEND;
          end
        end
        c_SEND: begin
          if (tx_flit_ready_i) begin
            r_beat <= r_beat + c_BEAT_W'(1);
            if (w_tail) begin
              r_state  <= c_IDLE;
              r_rr_ptr <= (r_vc == VC_W'(CH_NUM - 1)) ? '0 : r_vc + VC_W'(1);
            end
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  // A return arriving with the counter already full is an M1-side protocol error.
  always_ff @(posedge m2_clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < CH_NUM; i++) begin
        r_credit[i] <= c_CRED_W'(CREDIT_NUM);
      end
      r_overflow <= 1'b0;
    end else begin
      for (int i = 0; i < CH_NUM; i++) begin
        if (w_push[i] && !credit_return_i[i]) begin
          r_credit[i] <= r_credit[i] - c_CRED_W'(1);
        end else if (!w_push[i] && credit_return_i[i]) begin
          if (r_credit[i] == c_CRED_W'(CREDIT_NUM)) begin
            r_overflow <= 1'b1;
          end else begin
            r_credit[i] <= r_credit[i] + c_CRED_W'(1);
          end
        end
      end
    end
  end

  assign m2_m1_channel_push_ready_o = w_push;
  assign tx_flit_valid_o   = w_send;
  assign tx_flit_o         = w_send ? w_flit : '0;
  assign tx_flit_vc_o      = w_send ? r_vc : '0;
  assign tx_flit_head_o    = w_send && (r_beat == '0);
  assign tx_flit_tail_o    = w_send && w_tail;
  assign credit_overflow_o = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_m2_ebi_tx_packer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_m2_ebi_tx_packer : scoreboard bench for the M2->M1 flit packer
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_m2_ebi_tx_packer;
  import ebi_pkg::*;

  localparam int CH = 3;
  localparam int ML = MAX_M2_M1_MESSAGE_LENGTH;
  localparam int FW = 64;

  typedef struct {
    logic [FW-1:0] data;
    logic [1:0]    vc;
    logic          head;
    logic          tail;
  } flit_t;

  logic             clk = 1'b0;
  logic             rst_i;
  logic [CH-1:0]    valid;
  logic [CH-1:0]    push_ready;
  logic [CH*ML-1:0] entry;
  logic             tx_valid;
  logic             tx_ready;
  logic [FW-1:0]    tx_flit;
  logic [1:0]       tx_vc;
  logic             head;
  logic             tail;
  logic [CH-1:0]    cred_ret;
  logic             overflow;

  always #5 clk = ~clk;

  m2_ebi_tx_packer dut (
    .m2_clk_i                    (clk),
    .rst_i                       (rst_i),
    .m2_m1_channel_entry_valid_i (valid),
    .m2_m1_channel_push_ready_o  (push_ready),
    .m2_m1_channel_hs_entry_i    (entry),
    .tx_flit_valid_o             (tx_valid),
    .tx_flit_ready_i             (tx_ready),
    .tx_flit_o                   (tx_flit),
    .tx_flit_vc_o                (tx_vc),
    .tx_flit_head_o              (head),
    .tx_flit_tail_o              (tail),
    .credit_return_i             (cred_ret),
    .credit_overflow_o           (overflow)
  );

  int            n_pass  = 0;
  int            n_total = 0;
  flit_t         sb [$];
  logic [ML-1:0] src_q [CH][$];
  int            grant_log [$];
  bit            ready_q [$];
  bit            default_ready;
  logic [CH-1:0] consumed, auto_ret, pend_ret, ret_next;
  bit            prev_push, prev_stall;
  logic [FW-1:0] prev_flit;
  logic [3:0]    prev_meta;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic int exp_nflit(input int c);
    if (c == ID_B) return 1;
    if (c == ID_AC) return 2;
    return 4;
  endfunction

  function automatic logic [ML-1:0] rand_msg();
    logic [255:0] w;
    for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom();
    return w[ML-1:0];
  endfunction

  task automatic monitor();
    flit_t f;
    logic [255:0] wide;
    if (rst_i) begin
      prev_push  = 0;
      prev_stall = 0;
      return;
    end
    if (prev_push) begin
      check("first_flit_valid", 64'(tx_valid), 64'(1));
      check("first_flit_head", 64'(head), 64'(1));
    end
    if (tx_valid) check("no_grant_in_send", 64'(push_ready), 64'(0));
    if (prev_stall) begin
      check("stall_data", tx_flit, prev_flit);
      check("stall_meta", 64'({tx_vc, head, tail}), 64'(prev_meta));
    end
    if (push_ready != '0) begin
      check("push_onehot", 64'($countones(push_ready)), 64'(1));
      for (int c = 0; c < CH; c++) begin
        if (push_ready[c]) begin
          check("push_has_valid", 64'(valid[c]), 64'(1));
          grant_log.push_back(c);
          consumed[c] = 1'b1;
          wide = 256'(src_q[c][0]);
          for (int b = 0; b < exp_nflit(c); b++) begin
            f.data = wide[b*FW +: FW];
            f.vc   = 2'(c);
            f.head = (b == 0);
            f.tail = (b == exp_nflit(c) - 1);
            sb.push_back(f);
          end
        end
      end
    end
    if (tx_valid && tx_ready) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 64'(1), 64'(0));
      end else begin
        f = sb.pop_front();
        check("flit_data", tx_flit, f.data);
        check("flit_vc", 64'(tx_vc), 64'(f.vc));
        check("flit_head", 64'(head), 64'(f.head));
        check("flit_tail", 64'(tail), 64'(f.tail));
      end
      if (tail) ret_next[tx_vc] = auto_ret[tx_vc];
    end
    prev_push  = (push_ready != '0);
    prev_stall = tx_valid && !tx_ready;
    prev_flit  = tx_flit;
    prev_meta  = {tx_vc, head, tail};
  endtask

  task automatic drive();
    logic [ML-1:0] tmp;
    for (int c = 0; c < CH; c++) begin
      if (consumed[c] && src_q[c].size() > 0) tmp = src_q[c].pop_front();
      valid[c] = (src_q[c].size() > 0);
      entry[c*ML +: ML] = (src_q[c].size() > 0) ? src_q[c][0] : '0;
    end
    consumed = '0;
    cred_ret = pend_ret | ret_next;
    pend_ret = '0;
    ret_next = '0;
    tx_ready = (ready_q.size() > 0) ? ready_q.pop_front() : default_ready;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
    monitor();
  endtask

  function automatic bit src_busy();
    for (int c = 0; c < CH; c++) if (src_q[c].size() > 0) return 1;
    return 0;
  endfunction

  task automatic run_quiet(input bit with_src);
    int n = 0;
    while ((sb.size() != 0 || tx_valid || push_ready != '0 || (with_src && src_busy())) && n < 400) begin
      step();
      n++;
    end
    if (n >= 400) check("quiet_timeout", 64'(n), 64'(0));
    repeat (3) step();
  endtask

  task automatic wait_grants(input int k);
    int n = 0;
    while (grant_log.size() < k && n < 400) begin
      step();
      n++;
    end
    if (n >= 400) check("grant_timeout", 64'(grant_log.size()), 64'(k));
  endtask

  int ord [3];

  initial begin
    rst_i = 1; valid = '0; entry = '0; tx_ready = 0; cred_ret = '0;
    default_ready = 1; consumed = '0; auto_ret = '0; pend_ret = '0; ret_next = '0;
    prev_push = 0; prev_stall = 0; prev_flit = '0; prev_meta = '0;
    ord[0] = ID_B; ord[1] = ID_AC; ord[2] = ID_R;

    // Reset state
    repeat (3) step();
    check("rst_valid", 64'(tx_valid), 64'(0));
    check("rst_push", 64'(push_ready), 64'(0));
    check("rst_flit", tx_flit, 64'(0));
    check("rst_meta", 64'({tx_vc, head, tail}), 64'(0));
    check("rst_ovf", 64'(overflow), 64'(0));
    for (int c = 0; c < CH; c++) check("rst_credit", 64'(dut.r_credit[c]), 64'(2));
    rst_i = 0;

    // Single B message, ready held high
    src_q[ID_B].push_back(rand_msg());
    run_quiet(1);
    check("b_grants", 64'(grant_log.size()), 64'(1));
    check("b_grant_id", 64'(grant_log[0]), 64'(ID_B));
    check("b_credit", 64'(dut.r_credit[ID_B]), 64'(1));

    // R message with ready stalls (first entry covers the grant cycle)
    ready_q = '{1, 1, 0, 1, 1, 0, 1};
    src_q[ID_R].push_back(rand_msg());
    run_quiet(1);
    check("r_grant_id", 64'(grant_log[1]), 64'(ID_R));
    check("r_credit", 64'(dut.r_credit[ID_R]), 64'(1));

    // Restore credits, then all channels busy with credits recycled
    pend_ret = CH'((1 << ID_B) | (1 << ID_R));
    step(); step();
    for (int c = 0; c < CH; c++) check("restored_credit", 64'(dut.r_credit[c]), 64'(2));
    grant_log.delete();
    auto_ret = '1;
    for (int k = 0; k < 3; k++)
      for (int c = 0; c < CH; c++) src_q[c].push_back(rand_msg());
    run_quiet(1);
    check("rr_grants", 64'(grant_log.size()), 64'(9));
    for (int i = 0; i < 9 && i < grant_log.size(); i++)
      check("rr_order", 64'(grant_log[i]), 64'(ord[i % 3]));
    for (int c = 0; c < CH; c++) check("rr_credit", 64'(dut.r_credit[c]), 64'(2));

    // AC runs out of credit while B keeps being served
    grant_log.delete();
    auto_ret = CH'(1 << ID_B);
    for (int k = 0; k < 3; k++) begin
      src_q[ID_AC].push_back(rand_msg());
      src_q[ID_B].push_back(rand_msg());
    end
    wait_grants(5);
    run_quiet(0);
    check("blk_grants", 64'(grant_log.size()), 64'(5));
    for (int i = 0; i < 5 && i < grant_log.size(); i++)
      check("blk_order", 64'(grant_log[i]), 64'((i % 2 == 0) ? ID_B : ID_AC));
    check("ac_credit_zero", 64'(dut.r_credit[ID_AC]), 64'(0));
    check("ac_still_valid", 64'(valid[ID_AC]), 64'(1));
    repeat (6) begin
      step();
      check("ac_blocked", 64'(push_ready), 64'(0));
    end
    pend_ret = CH'(1 << ID_AC);
    wait_grants(6);
    if (grant_log.size() > 5) check("ac_unblocked", 64'(grant_log[5]), 64'(ID_AC));
    run_quiet(1);
    auto_ret = '0;

    // Credit overflow on B
    check("ovf_pre_credit", 64'(dut.r_credit[ID_B]), 64'(2));
    check("ovf_pre_flag", 64'(overflow), 64'(0));
    pend_ret = CH'(1 << ID_B);
    step(); step();
    check("ovf_credit_sat", 64'(dut.r_credit[ID_B]), 64'(2));
    check("ovf_flag", 64'(overflow), 64'(1));
    repeat (4) step();
    check("ovf_sticky", 64'(overflow), 64'(1));
    rst_i = 1;
    step(); step();
    check("ovf_cleared", 64'(overflow), 64'(0));
    rst_i = 0;
    step();

    // Reset in the middle of a stalled R message
    default_ready = 0;
    src_q[ID_R].push_back(rand_msg());
    step(); step();
    check("mid_valid", 64'(tx_valid), 64'(1));
    rst_i = 1;
    sb.delete();
    step(); step();
    check("mid_rst_valid", 64'(tx_valid), 64'(0));
    rst_i = 0;
    default_ready = 1;
    repeat (5) begin
      step();
      check("post_rst_quiet", 64'({tx_valid, push_ready}), 64'(0));
    end
    check("post_rst_credit", 64'(dut.r_credit[ID_R]), 64'(2));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
